// File: rtl/dcache_sram_nway_if.sv
// Bus bundle for dcache_sram_nway: lookup/write port, flush control and write-back stream.
// Signal names keep the original port names so that controller-side code maps one-to-one.
interface dcache_sram_nway_if #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 16,
  parameter int unsigned TAG_W  = 25,
  parameter int unsigned LINE_W = 256
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic [IDX_W-1:0]  addr_i;
  logic [TAG_W-1:0]  tag_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic [TAG_W-1:0]  tag_o;
  logic [LINE_W-1:0] data_o;
  logic              hit_o;
  logic [WAY_W-1:0]  hit_way_o;
  logic              flush_i;
  logic              busy_o;
  logic              flush_done_o;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [IDX_W-1:0]  wb_set_o;
  logic [TAG_W-1:0]  wb_tag_o;
  logic [LINE_W-1:0] wb_data_o;

  modport slave (
    input  addr_i, tag_i, data_i, enable_i, write_i, flush_i, wb_ready_i,
    output tag_o, data_o, hit_o, hit_way_o, busy_o, flush_done_o,
           wb_valid_o, wb_set_o, wb_tag_o, wb_data_o
  );

  modport master (
    output addr_i, tag_i, data_i, enable_i, write_i, flush_i, wb_ready_i,
    input  tag_o, data_o, hit_o, hit_way_o, busy_o, flush_done_o,
           wb_valid_o, wb_set_o, wb_tag_o, wb_data_o
  );
endinterface

// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache storage with true-LRU replacement and a dirty-line flush engine.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_sram_nway #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 16,
  parameter int unsigned TAG_W  = 25,
  parameter int unsigned LINE_W = 256
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  dcache_sram_nway_if.slave  bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned AT_W  = TAG_W - 2;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_q [SETS][WAYS];
  logic [WAY_W-1:0]  age_q  [SETS][WAYS];
  logic [IDX_W-1:0]  scan_set_q;
  logic [WAY_W-1:0]  scan_way_q;

  logic              match_any, inv_any, idle, hit, wr, lru_upd;
  logic [WAY_W-1:0]  match_way, victim_way, sel_way, sel_age;
  logic [TAG_W-1:0]  scan_tag;
  logic              scan_dirty, advance, last;

  always_comb begin
    match_any  = 1'b0;
    match_way  = '0;
    inv_any    = 1'b0;
    victim_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!match_any && tag_q[bus.addr_i][w][TAG_W-1] &&
          tag_q[bus.addr_i][w][AT_W-1:0] == bus.tag_i[AT_W-1:0]) begin
        match_any = 1'b1;
        match_way = WAY_W'(w);
      end
      if (!inv_any && !tag_q[bus.addr_i][w][TAG_W-1]) begin
        inv_any    = 1'b1;
        victim_way = WAY_W'(w);
      end
    end
    // Ages form a permutation, so exactly one way carries the oldest age.
    if (!inv_any) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[bus.addr_i][w] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
      end
    end
  end

  assign idle    = (state_q == IDLE);
  assign hit     = bus.enable_i & match_any & idle;
  assign sel_way = hit ? match_way : victim_way;
  assign sel_age = age_q[bus.addr_i][sel_way];
  assign wr      = bus.enable_i & bus.write_i & idle;
  assign lru_upd = bus.enable_i & idle & (hit | bus.write_i);

  assign bus.hit_o     = hit;
  assign bus.hit_way_o = sel_way;
  assign bus.tag_o     = tag_q[bus.addr_i][sel_way];
  assign bus.data_o    = data_q[bus.addr_i][sel_way];

  assign scan_tag   = tag_q[scan_set_q][scan_way_q];
  assign scan_dirty = (state_q == SCAN) & scan_tag[TAG_W-1] & scan_tag[TAG_W-2];
  assign advance    = (state_q == SCAN) & (~scan_dirty | bus.wb_ready_i);
  assign last       = (scan_set_q == IDX_W'(SETS - 1)) && (scan_way_q == WAY_W'(WAYS - 1));

  assign bus.wb_valid_o = scan_dirty;
  assign bus.wb_set_o   = scan_set_q;
  assign bus.wb_tag_o   = scan_tag;
  assign bus.wb_data_o  = data_q[scan_set_q][scan_way_q];

  always_comb begin
    state_d          = state_q;
    bus.busy_o       = 1'b0;
    bus.flush_done_o = 1'b0;
    case (state_q)
      IDLE: if (bus.flush_i) state_d = SCAN;
      SCAN: begin
        bus.busy_o = 1'b1;
        if (advance && last) state_d = DONE;
      end
      DONE: begin
        bus.busy_o       = 1'b1;
        bus.flush_done_o = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Way is the low part of the pointer, so one increment walks ways before sets.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scan_set_q <= '0;
      scan_way_q <= '0;
    end else if (idle && bus.flush_i) begin
      scan_set_q <= '0;
      scan_way_q <= '0;
    end else if (advance) begin
      {scan_set_q, scan_way_q} <= {scan_set_q, scan_way_q} + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
          age_q[s][w]  <= WAY_W'(w);
        end
      end
    end else begin
      if (wr) begin
        tag_q[bus.addr_i][sel_way]  <= bus.tag_i;
        data_q[bus.addr_i][sel_way] <= bus.data_i;
      end
      if (lru_upd) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == sel_way)               age_q[bus.addr_i][w] <= '0;
          else if (age_q[bus.addr_i][w] < sel_age) age_q[bus.addr_i][w] <= age_q[bus.addr_i][w] + 1'b1;
        end
      end
      if (scan_dirty && bus.wb_ready_i) tag_q[scan_set_q][scan_way_q][TAG_W-2] <= 1'b0;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        rd;

  assign rd = bus.enable_i & ~bus.write_i & idle;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rd) begin
      if (hit && hit_cnt_q != '1)        hit_cnt_q  <= hit_cnt_q + 1'b1;
      else if (!hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed self-checking bench for dcache_sram_nway: lookup/LRU vector table plus flush and reset sequences.
// Counter checks are compiled when DCACHE_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module tb_dcache_sram_nway;
  localparam int unsigned WAYS = 4, SETS = 16, TAG_W = 25, LINE_W = 256;
  localparam int unsigned IDX_W = 4, WAY_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_sram_nway_if #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) bus ();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [IDX_W-1:0] addr;
    logic [TAG_W-1:0] tag;
    int unsigned      dk;
    logic             en;
    logic             wr;
    logic             hit;
    logic [WAY_W-1:0] way;
    logic [TAG_W-1:0] etag;
    int unsigned      edk;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [LINE_W-1:0] d(input int unsigned k);
    logic [31:0] w;
    w = 32'hA500_0000 | k;
    return (k == 0) ? '0 : {8{w}};
  endfunction

  function automatic vec_t mk(input logic [IDX_W-1:0] a, input logic [TAG_W-1:0] t,
                              input int unsigned dk, input logic en, input logic wr,
                              input logic h, input logic [WAY_W-1:0] w,
                              input logic [TAG_W-1:0] et, input int unsigned edk);
    vec_t v;
    v.addr = a; v.tag = t; v.dk = dk; v.en = en; v.wr = wr;
    v.hit = h; v.way = w; v.etag = et; v.edk = edk;
    return v;
  endfunction

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic write_line(input logic [IDX_W-1:0] a, input logic [TAG_W-1:0] t, input int unsigned k);
    bus.addr_i = a; bus.tag_i = t; bus.data_i = d(k);
    bus.enable_i = 1'b1; bus.write_i = 1'b1;
    step();
    bus.enable_i = 1'b0; bus.write_i = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [IDX_W-1:0] a, input logic [TAG_W-1:0] t,
                        input logic h, input logic [WAY_W-1:0] w,
                        input logic [TAG_W-1:0] et, input int unsigned edk);
    bus.addr_i = a; bus.tag_i = t;
    bus.enable_i = 1'b1; bus.write_i = 1'b0;
    #1;
    check({name, ".hit"}, bus.hit_o, h);
    check({name, ".way"}, bus.hit_way_o, w);
    check({name, ".tag"}, bus.tag_o, et);
    check({name, ".data"}, bus.data_o, d(edk));
    step();
    bus.enable_i = 1'b0;
  endtask

  int unsigned busy_cyc, done_cnt, stalls, n_pres;
  int unsigned pres [4];
  logic        unstable, hit_seen, seen;

  initial begin
    bus.addr_i = '0; bus.tag_i = '0; bus.data_i = '0;
    bus.enable_i = 1'b0; bus.write_i = 1'b0;
    bus.flush_i = 1'b0; bus.wb_ready_i = 1'b0;

    // Ages after each access are tracked by hand in the expected victim/hit way column.
    vecs[0]  = mk(5, 25'h1000123, 0, 1, 0, 0, 0, 25'h0,       0);
    vecs[1]  = mk(3, 25'h1000001, 1, 1, 1, 0, 0, 25'h0,       0);
    vecs[2]  = mk(3, 25'h1000002, 2, 1, 1, 0, 1, 25'h0,       0);
    vecs[3]  = mk(3, 25'h1000003, 3, 1, 1, 0, 2, 25'h0,       0);
    vecs[4]  = mk(3, 25'h1000004, 4, 1, 1, 0, 3, 25'h0,       0);
    vecs[5]  = mk(3, 25'h1000001, 0, 1, 0, 1, 0, 25'h1000001, 1);
    vecs[6]  = mk(3, 25'h1000005, 5, 1, 1, 0, 1, 25'h1000002, 2);
    vecs[7]  = mk(3, 25'h1000002, 0, 1, 0, 0, 2, 25'h1000003, 3);
    vecs[8]  = mk(3, 25'h1800003, 9, 1, 1, 1, 2, 25'h1000003, 3);
    vecs[9]  = mk(3, 25'h1000003, 0, 1, 0, 1, 2, 25'h1800003, 9);
    vecs[10] = mk(3, 25'h1000004, 0, 1, 0, 1, 3, 25'h1000004, 4);
    vecs[11] = mk(3, 25'h1000005, 0, 1, 0, 1, 1, 25'h1000005, 5);
    vecs[12] = mk(3, 25'h1000001, 0, 1, 0, 1, 0, 25'h1000001, 1);
    vecs[13] = mk(3, 25'h1000001, 0, 0, 0, 0, 2, 25'h1800003, 9);

    do_reset();
    check("rst.busy", bus.busy_o, 1'b0);
    check("rst.wb_valid", bus.wb_valid_o, 1'b0);
    check("rst.flush_done", bus.flush_done_o, 1'b0);

    for (int i = 0; i < 14; i++) begin
      bus.addr_i = vecs[i].addr; bus.tag_i = vecs[i].tag; bus.data_i = d(vecs[i].dk);
      bus.enable_i = vecs[i].en; bus.write_i = vecs[i].wr;
      #1;
      check($sformatf("v%0d.hit", i), bus.hit_o, vecs[i].hit);
      check($sformatf("v%0d.way", i), bus.hit_way_o, vecs[i].way);
      check($sformatf("v%0d.tag", i), bus.tag_o, vecs[i].etag);
      check($sformatf("v%0d.data", i), bus.data_o, d(vecs[i].edk));
      check($sformatf("v%0d.busy", i), bus.busy_o, 1'b0);
      step();
    end
    bus.enable_i = 1'b0; bus.write_i = 1'b0;

    // Flush with a 3-cycle stall on the first dirty line and writes attempted while busy.
    do_reset();
    lookup("postrst", 3, 25'h1000001, 0, 0, 25'h0, 0);
    write_line(0, 25'h1800010, 16);
    write_line(15, 25'h1800020, 17);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    bus.addr_i = 0; bus.tag_i = 25'h1000010; bus.data_i = d(99);
    bus.enable_i = 1'b1; bus.write_i = 1'b1;
    busy_cyc = 0; done_cnt = 0; stalls = 0; n_pres = 0;
    unstable = 1'b0; hit_seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (!bus.busy_o) break;
      busy_cyc++;
      if (bus.hit_o) hit_seen = 1'b1;
      if (bus.flush_done_o) done_cnt++;
      if (bus.wb_valid_o) begin
        if (bus.wb_set_o == 0 && stalls < 3) begin
          bus.wb_ready_i = 1'b0;
          stalls++;
          if (bus.wb_tag_o !== 25'h1800010 || bus.wb_data_o !== d(16)) unstable = 1'b1;
        end else begin
          bus.wb_ready_i = 1'b1;
          if (n_pres < 4) pres[n_pres] = bus.wb_set_o;
          n_pres++;
        end
      end else begin
        bus.wb_ready_i = 1'b0;
      end
      @(posedge clk);
    end
    #1;
    bus.wb_ready_i = 1'b0; bus.enable_i = 1'b0; bus.write_i = 1'b0;
    check("flush.busy_cycles", busy_cyc, 68);
    check("flush.done_pulses", done_cnt, 1);
    check("flush.stalls", stalls, 3);
    check("flush.stall_stable", unstable, 1'b0);
    check("flush.hit_while_busy", hit_seen, 1'b0);
    check("flush.presented", n_pres, 2);
    check("flush.pres0_set", pres[0], 0);
    check("flush.pres1_set", pres[1], 15);
    check("flush.wb_valid_after", bus.wb_valid_o, 1'b0);
    check("flush.done_after", bus.flush_done_o, 1'b0);
    lookup("flush.set0", 0, 25'h1000010, 1, 0, 25'h1000010, 16);
    lookup("flush.set15", 15, 25'h1000020, 1, 0, 25'h1000020, 17);

    // Reset asserted while a dirty line is being presented.
    write_line(2, 25'h1800040, 18);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.wb_valid_o) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("rstscan.wb_valid_seen", seen, 1'b1);
    check("rstscan.wb_set", bus.wb_set_o, 2);
    rst_n = 1'b0;
    #1;
    check("rstscan.busy", bus.busy_o, 1'b0);
    check("rstscan.wb_valid", bus.wb_valid_o, 1'b0);
    check("rstscan.flush_done", bus.flush_done_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    lookup("rstscan.set2", 2, 25'h1000040, 0, 0, 25'h0, 0);
    lookup("rstscan.set0", 0, 25'h1000010, 0, 0, 25'h0, 0);
    lookup("rstscan.set15", 15, 25'h1000020, 0, 0, 25'h0, 0);

`ifdef DCACHE_PERF_CNT_EN
    do_reset();
    write_line(4, 25'h1000050, 20);
    for (int i = 0; i < 3; i++) lookup("perf.hit", 4, 25'h1000050, 1, 0, 25'h1000050, 20);
    for (int i = 0; i < 2; i++) lookup("perf.miss", 4, 25'h1000051, 0, 1, 25'h0, 0);
    check("perf.hit_cnt", hit_cnt, 32'd3);
    check("perf.miss_cnt", miss_cnt, 32'd2);
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.hit_cnt_q;
    lookup("perf.sat_hit", 4, 25'h1000050, 1, 0, 25'h1000050, 20);
    check("perf.hit_sat", hit_cnt, 32'hFFFF_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
